// File: rtl/bk_sector_sequencer.sv
// bk_sector_sequencer
//
// Moves save-state backup data between the system backup RAM and the
// HPS-mounted save image, one 512-byte sector at a time. The sequencer arms
// itself when a writable save image is mounted during ROM download. It edge
// detects load/save menu requests and walks all 2**SECTOR_BITS sectors of the
// selected slot through the sd_lba/sd_rd/sd_wr/sd_ack handshake.
//
// Parameters
//   SECTOR_BITS  log2 sectors per slot
//   SLOT_BITS    save slot select width
//   TIMEOUT_W    ack watchdog width; a transfer aborts after 2**TIMEOUT_W-1
//                cycles without an sd_ack edge
//
// Ports
//   clk_sys       in   system clock
//   RESET_n       in   asynchronous active-low reset
//   dl_active     in   ROM download in progress (level)
//   img_mounted   in   image-mounted strobe
//   img_size_nz   in   mounted image size is non-zero
//   img_readonly  in   mounted image is read-only
//   load_req      in   load-state request level
//   save_req      in   save-state request level
//   slot          in   save slot, sampled when a request is accepted
//   sd_ack        in   sector ack, high while the HPS transfers a sector
//   sd_lba        out  {slot, sector}, zero-extended to 32 bits
//   sd_rd         out  sector read request (load)
//   sd_wr         out  sector write request (save)
//   bk_ena        out  save image armed
//   busy          out  transfer in progress
//   loading       out  load in progress (console held in reset)
//   err           out  last transfer aborted by the watchdog (sticky)

module bk_sector_sequencer #(
    parameter int SECTOR_BITS = 6,
    parameter int SLOT_BITS   = 2,
    parameter int TIMEOUT_W   = 24
) (
    input  logic                 clk_sys,
    input  logic                 RESET_n,
    input  logic                 dl_active,
    input  logic                 img_mounted,
    input  logic                 img_size_nz,
    input  logic                 img_readonly,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 sd_ack,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 bk_ena,
    output logic                 busy,
    output logic                 loading,
    output logic                 err
);

    localparam int LBA_W = SLOT_BITS + SECTOR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   dl_q;
    logic                   ld_q;
    logic                   sv_q;
    logic                   ack_q;
    logic [SLOT_BITS-1:0]   slot_q;
    logic [SECTOR_BITS-1:0] sector_q;
    logic                   dir_q;      // 1 = load (read image), 0 = save
    logic                   rd_q;
    logic                   wr_q;
    logic                   bk_ena_q;
    logic                   busy_q;
    logic                   loading_q;
    logic                   err_q;
    logic [TIMEOUT_W-1:0]   wdog_q;

    logic                   dl_rise;
    logic                   ld_rise;
    logic                   sv_rise;
    logic                   ack_rise;
    logic                   ack_fall;
    logic                   arm_set;
    logic                   accept;
    logic [TIMEOUT_W-1:0]   wdog_inc;
    logic                   wdog_expire;

    assign dl_rise  = dl_active & ~dl_q;
    assign ld_rise  = load_req & ~ld_q;
    assign sv_rise  = save_req & ~sv_q;
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign arm_set  = dl_active & img_mounted & img_size_nz & ~img_readonly;

    // Rises outside IDLE or while unarmed are simply lost; nothing is queued.
    assign accept = (state_q == ST_IDLE) & bk_ena_q & (ld_rise | sv_rise);

    // Abort on the cycle the counter would reach all ones, so the request
    // is withdrawn exactly 2**TIMEOUT_W-1 cycles after the last ack edge.
    assign wdog_inc    = wdog_q + 1'b1;
    assign wdog_expire = &wdog_inc;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            dl_q      <= 1'b0;
            ld_q      <= 1'b0;
            sv_q      <= 1'b0;
            ack_q     <= 1'b0;
            slot_q    <= '0;
            sector_q  <= '0;
            dir_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            bk_ena_q  <= 1'b0;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            err_q     <= 1'b0;
            wdog_q    <= '0;
        end else begin
            dl_q  <= dl_active;
            ld_q  <= load_req;
            sv_q  <= save_req;
            ack_q <= sd_ack;

            // A mount in the same cycle as the download edge keeps the image armed.
            if (arm_set) begin
                bk_ena_q <= 1'b1;
            end else if (dl_rise) begin
                bk_ena_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // Load wins when both requests rise together.
                        slot_q    <= slot;
                        sector_q  <= '0;
                        dir_q     <= ld_rise;
                        rd_q      <= ld_rise;
                        wr_q      <= ~ld_rise;
                        busy_q    <= 1'b1;
                        loading_q <= ld_rise;
                        err_q     <= 1'b0;
                        wdog_q    <= '0;
                        state_q   <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (ack_rise) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        wdog_q  <= '0;
                        state_q <= ST_XFER;
                    end else if (wdog_expire) begin
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                        wdog_q    <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end

                ST_XFER: begin
                    if (ack_fall) begin
                        wdog_q <= '0;
                        if (&sector_q) begin
                            busy_q    <= 1'b0;
                            loading_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            // Sector field wraps on its own; the slot never changes.
                            sector_q <= sector_q + 1'b1;
                            rd_q     <= dir_q;
                            wr_q     <= ~dir_q;
                            state_q  <= ST_REQ;
                        end
                    end else if (wdog_expire) begin
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                        wdog_q    <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end

                default: begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sd_lba  = {{(32-LBA_W){1'b0}}, slot_q, sector_q};
    assign sd_rd   = rd_q;
    assign sd_wr   = wr_q;
    assign bk_ena  = bk_ena_q;
    assign busy    = busy_q;
    assign loading = loading_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bk_sector_sequencer.sv
// Directed testbench for bk_sector_sequencer (TIMEOUT_W=4 so the watchdog
// expires after 15 cycles without an ack edge).

module tb_bk_sector_sequencer;

    logic        clk_sys      = 1'b0;
    logic        RESET_n      = 1'b0;
    logic        dl_active    = 1'b0;
    logic        img_mounted  = 1'b0;
    logic        img_size_nz  = 1'b0;
    logic        img_readonly = 1'b0;
    logic        load_req     = 1'b0;
    logic        save_req     = 1'b0;
    logic [1:0]  slot         = 2'd0;
    logic        sd_ack       = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        bk_ena;
    logic        busy;
    logic        loading;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    bk_sector_sequencer #(
        .SECTOR_BITS(6),
        .SLOT_BITS  (2),
        .TIMEOUT_W  (4)
    ) dut (
        .clk_sys     (clk_sys),
        .RESET_n     (RESET_n),
        .dl_active   (dl_active),
        .img_mounted (img_mounted),
        .img_size_nz (img_size_nz),
        .img_readonly(img_readonly),
        .load_req    (load_req),
        .save_req    (save_req),
        .slot        (slot),
        .sd_ack      (sd_ack),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .bk_ena      (bk_ena),
        .busy        (busy),
        .loading     (loading),
        .err         (err)
    );

    // Request activity monitor, sampled away from the active edge.
    always @(negedge clk_sys) begin
        if (sd_rd) rd_cnt <= rd_cnt + 1;
        if (sd_wr) wr_cnt <= wr_cnt + 1;
        if (sd_rd && sd_wr) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_req(output int w);
        w = 0;
        while (!(sd_rd || sd_wr) && w < 20) begin
            tick();
            w++;
        end
    endtask

    task automatic arm();
        dl_active    = 1'b1;
        img_mounted  = 1'b1;
        img_size_nz  = 1'b1;
        img_readonly = 1'b0;
        tick();
        img_mounted = 1'b0;
        dl_active   = 1'b0;
        tick();
    endtask

    // Acks nsec sectors starting at LBA base (ack held high 3 cycles each).
    task automatic run_sectors(input bit is_load, input logic [7:0] base, input int nsec);
        for (int s = 0; s < nsec; s++) begin
            int w;
            wait_req(w);
            chk("req_latency", w, 0);
            chk("lba", sd_lba, {24'h0, base} + s);
            chk("dir", {sd_rd, sd_wr}, is_load ? 2'b10 : 2'b01);
            chk("busy_xfer", busy, 1'b1);
            chk("loading_xfer", loading, is_load);
            sd_ack = 1'b1;
            tick();
            chk("req_clear", {sd_rd, sd_wr}, 2'b00);
            tick();
            tick();
            sd_ack = 1'b0;
            tick();
        end
        if (nsec == 64) begin
            chk("end_busy", busy, 1'b0);
            chk("end_loading", loading, 1'b0);
            chk("end_req", {sd_rd, sd_wr}, 2'b00);
            chk("end_err", err, 1'b0);
        end
    endtask

    initial begin
        int base_rd;
        int base_wr;
        int n;

        // Reset state
        tick();
        tick();
        chk("rst_lba", sd_lba, 32'h0);
        chk("rst_rd", sd_rd, 1'b0);
        chk("rst_wr", sd_wr, 1'b0);
        chk("rst_bk_ena", bk_ena, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_loading", loading, 1'b0);
        chk("rst_err", err, 1'b0);
        RESET_n = 1'b1;
        tick();

        // Arming
        dl_active    = 1'b1;
        img_mounted  = 1'b1;
        img_size_nz  = 1'b1;
        img_readonly = 1'b1;
        tick();
        img_mounted = 1'b0;
        tick();
        chk("arm_readonly", bk_ena, 1'b0);
        img_readonly = 1'b0;
        img_mounted  = 1'b1;
        tick();
        img_mounted = 1'b0;
        chk("arm", bk_ena, 1'b1);
        dl_active = 1'b0;
        tick();
        chk("arm_hold", bk_ena, 1'b1);
        dl_active = 1'b1;
        tick();
        chk("dl_rise_clear", bk_ena, 1'b0);
        img_size_nz = 1'b0;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        img_size_nz = 1'b1;
        chk("arm_size_zero", bk_ena, 1'b0);
        dl_active = 1'b0;
        tick();
        dl_active   = 1'b1;
        img_mounted = 1'b1;
        tick();
        chk("arm_priority", bk_ena, 1'b1);
        img_mounted = 1'b0;
        dl_active   = 1'b0;
        tick();

        // Save slot 2; slot input changes after acceptance
        base_rd  = rd_cnt;
        slot     = 2'd2;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        slot     = 2'd1;
        chk("save_first_wr", sd_wr, 1'b1);
        run_sectors(1'b0, 8'h80, 64);
        chk("save_no_rd", rd_cnt - base_rd, 0);

        // Load slot 0
        base_wr  = wr_cnt;
        slot     = 2'd0;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("load_loading", loading, 1'b1);
        run_sectors(1'b1, 8'h00, 64);
        chk("load_no_wr", wr_cnt - base_wr, 0);

        // Simultaneous rises: load wins; requests and dl rise while busy
        base_wr  = wr_cnt;
        slot     = 2'd3;
        load_req = 1'b1;
        save_req = 1'b1;
        tick();
        load_req = 1'b0;
        save_req = 1'b0;
        chk("both_is_load", {sd_rd, sd_wr}, 2'b10);
        tick();
        save_req  = 1'b1;
        load_req  = 1'b1;
        dl_active = 1'b1;
        tick();
        save_req  = 1'b0;
        load_req  = 1'b0;
        dl_active = 1'b0;
        chk("mid_dl_clear", bk_ena, 1'b0);
        chk("mid_busy", busy, 1'b1);
        run_sectors(1'b1, 8'hC0, 64);
        chk("both_no_wr", wr_cnt - base_wr, 0);

        // Request with bk_ena=0 is dropped
        base_wr  = wr_cnt;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        tick();
        tick();
        tick();
        chk("unarmed_busy", busy, 1'b0);
        chk("unarmed_no_wr", wr_cnt - base_wr, 0);

        // Watchdog: never ack
        arm();
        slot     = 2'd1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("wd_start_rd", sd_rd, 1'b1);
        n = 0;
        while (sd_rd && n < 40) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 15);
        chk("wd_err", err, 1'b1);
        chk("wd_busy", busy, 1'b0);
        chk("wd_loading", loading, 1'b0);
        chk("wd_req", {sd_rd, sd_wr}, 2'b00);

        // Next accepted request clears err; then reset mid-transfer
        slot     = 2'd0;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        chk("err_cleared", err, 1'b0);
        run_sectors(1'b0, 8'h00, 10);
        chk("lba_sector10", sd_lba, 32'h0A);
        sd_ack = 1'b1;
        tick();
        #2;
        RESET_n = 1'b0;
        #1;
        chk("async_lba", sd_lba, 32'h0);
        chk("async_wr", sd_wr, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_bk_ena", bk_ena, 1'b0);
        chk("async_err", err, 1'b0);
        sd_ack = 1'b0;
        tick();
        RESET_n = 1'b1;
        tick();

        // Fresh save restarts at sector 0
        arm();
        slot     = 2'd0;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        chk("restart_lba", sd_lba, 32'h0);
        run_sectors(1'b0, 8'h00, 64);

        chk("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
